// File: rtl/out_gain_if.sv
// Sample/control bundle between the delay stage, the analog controls and the
// output gain stage that feeds the DAC SPI driver.
interface out_gain_if #(
  parameter int SIG_BITS = 16,
  parameter int GAIN_B   = 8
);
  logic [SIG_BITS-1:0] in_data;
  logic                in_valid;
  logic [GAIN_B-1:0]   gain;
  logic                mute;
  logic                peak_clr;
  logic [SIG_BITS-1:0] out_data;
  logic                out_valid;
  logic                ramping;
  logic [SIG_BITS-2:0] peak;

  modport master (
    output in_data, in_valid, gain, mute, peak_clr,
    input  out_data, out_valid, ramping, peak
  );

  modport slave (
    input  in_data, in_valid, gain, mute, peak_clr,
    output out_data, out_valid, ramping, peak
  );
endinterface

// File: rtl/out_gain.sv
// Output gain stage: click-free gain ramp (one LSB per sample), two-stage
// offset-binary multiply pipeline and peak-magnitude tracker.
module out_gain #(
  parameter int SIG_BITS = 16,
  parameter int GAIN_B   = 8
) (
  input logic       clk,
  input logic       reset_n,
  out_gain_if.slave bus
);

  localparam int PW = SIG_BITS + GAIN_B + 1;
  localparam logic signed [PW-1:0] SMAX = {{(GAIN_B+2){1'b0}}, {(SIG_BITS-1){1'b1}}};
  localparam logic signed [PW-1:0] SMIN = {{(GAIN_B+2){1'b1}}, {(SIG_BITS-1){1'b0}}};

  typedef enum logic [1:0] {STEADY, RAMP_UP, RAMP_DOWN} ramp_state_t;

  function automatic logic signed [SIG_BITS-1:0] sat_sample(input logic signed [PW-1:0] v);
    if (v > SMAX)      sat_sample = {1'b0, {(SIG_BITS-1){1'b1}}};
    else if (v < SMIN) sat_sample = {1'b1, {(SIG_BITS-1){1'b0}}};
    else               sat_sample = SIG_BITS'(v);
  endfunction

  function automatic logic [SIG_BITS-2:0] mag_sat(input logic signed [SIG_BITS-1:0] v);
    if (!v[SIG_BITS-1])                          mag_sat = v[SIG_BITS-2:0];
    else if (v == {1'b1, {(SIG_BITS-1){1'b0}}}) mag_sat = '1;
    else                                         mag_sat = (SIG_BITS-1)'(-v);
  endfunction

  ramp_state_t                state;
  logic        [GAIN_B-1:0]   tgt;
  logic        [GAIN_B-1:0]   cur_gain;
  logic        [GAIN_B-1:0]   cur_gain_next;

  logic signed [SIG_BITS-1:0] s_p1;
  logic        [GAIN_B-1:0]   gain_p1;
  logic                       vld_p1;
  logic signed [PW-1:0]       s_ext;
  logic signed [PW-1:0]       g_ext;
  logic signed [PW-1:0]       prod;
  logic signed [SIG_BITS-1:0] r;
  logic        [SIG_BITS-1:0] out_data_p2;
  logic        [SIG_BITS-2:0] mag_p2;
  logic                       vld_p2;
  logic        [SIG_BITS-2:0] peak_q;

  // Ramp control: state follows the registered gain, steps only on samples.
  always_comb begin
    tgt           = bus.mute ? '0 : bus.gain;
    state         = STEADY;
    cur_gain_next = cur_gain;
    if (cur_gain < tgt)      state = RAMP_UP;
    else if (cur_gain > tgt) state = RAMP_DOWN;
    if (bus.in_valid) begin
      case (state)
        RAMP_UP:   cur_gain_next = cur_gain + GAIN_B'(1);
        RAMP_DOWN: cur_gain_next = cur_gain - GAIN_B'(1);
        default:   cur_gain_next = cur_gain;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cur_gain <= '0;
    else          cur_gain <= cur_gain_next;
  end

  assign bus.ramping = (state != STEADY);

  // Stage 1: signed sample plus the pre-update gain.
  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      s_p1    <= $signed({~bus.in_data[SIG_BITS-1], bus.in_data[SIG_BITS-2:0]});
      gain_p1 <= cur_gain;
    end
  end

  // Stage 2: multiply by the unsigned gain and floor-shift back to sample width.
  always_comb begin
    s_ext = PW'(s_p1);
    g_ext = $signed(PW'({1'b0, gain_p1}));
    prod  = s_ext * g_ext;
    r     = sat_sample(prod >>> GAIN_B);
  end

  always_ff @(posedge clk) begin
    if (vld_p1) mag_p2 <= mag_sat(r);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      out_data_p2 <= {1'b1, {(SIG_BITS-1){1'b0}}};
    end else begin
      vld_p1 <= bus.in_valid;
      vld_p2 <= vld_p1;
      if (vld_p1) out_data_p2 <= {~r[SIG_BITS-1], r[SIG_BITS-2:0]};
    end
  end

  // Peak tracker: a clear coinciding with a new result keeps that result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      peak_q <= '0;
    end else if (vld_p2) begin
      if (bus.peak_clr || (mag_p2 > peak_q)) peak_q <= mag_p2;
    end else if (bus.peak_clr) begin
      peak_q <= '0;
    end
  end

  assign bus.out_data  = out_data_p2;
  assign bus.out_valid = vld_p2;
  assign bus.peak      = peak_q;

endmodule

// File: doc/out_gain.md
OUT_GAIN -- requirements
Module: out_gain

Interface
REQ-001 Parameter: SIG_BITS, default 16, width of the sample path in offset-binary format (midscale = 2^(SIG_BITS-1)).
REQ-002 Parameter: GAIN_B, default 8, width of the gain control word.
REQ-003 Port: clk  input  1  system clock, 50 MHz domain; the block has one clock, all logic on its rising edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: in_data  input  SIG_BITS  offset-binary sample from the delay stage.
REQ-006 Port: in_valid  input  1  single-cycle qualifier for in_data.
REQ-007 Port: gain  input  GAIN_B  target gain from the analog controls; effective gain = gain/2^GAIN_B.
REQ-008 Port: mute  input  1  when high, the target gain is forced to 0.
REQ-009 Port: peak_clr  input  1  single-cycle clear of the peak register.
REQ-010 Port: out_data  output  SIG_BITS  offset-binary sample to the DAC SPI driver.
REQ-011 Port: out_valid  output  1  single-cycle qualifier for out_data, used as the DAC go.
REQ-012 Port: ramping  output  1  high while the current gain differs from the target gain.
REQ-013 Port: peak  output  SIG_BITS-1  maximum output magnitude seen since the last clear or reset.

Function
REQ-014 Target gain: tgt = 0 when mute = 1; otherwise tgt = gain, sampled on every cycle.
REQ-015 cur_gain, GAIN_B bits, is the gain applied to samples; it changes only on cycles with in_valid = 1.
REQ-016 On each in_valid, the sample shall use the pre-update cur_gain.
REQ-017 On each in_valid, cur_gain shall step by exactly 1 toward tgt (+1 if below, -1 if above, unchanged if equal); it shall never overshoot.
REQ-018 Ramp states: STEADY (cur_gain = tgt), RAMP_UP (cur_gain < tgt), RAMP_DOWN (cur_gain > tgt); the state is re-evaluated every cycle from the registered cur_gain and tgt; ramping = (state != STEADY).
REQ-019 Stage 1 registers the signed sample s = in_data with its MSB inverted (s = in_data - 2^(SIG_BITS-1)), together with the applied gain and a valid bit.
REQ-020 Stage 2 computes p = s * gain_applied, treating the gain as unsigned and p as a signed SIG_BITS+GAIN_B+1 bit value.
REQ-021 Stage 2 then forms r = p arithmetically shifted right by GAIN_B (truncation toward minus infinity) and registers out_data = r[SIG_BITS-1:0] with its MSB inverted; r cannot overflow because gain < 1.
REQ-022 Latency: out_valid shall assert exactly 2 cycles after the in_valid that produced it; back-to-back in_valid on consecutive cycles shall be fully supported with no drops.
REQ-023 out_valid shall be high for exactly one cycle per input sample; out_data shall hold its value between valid pulses.
REQ-024 Peak: on out_valid, peak <= max(peak, |r|), where |r| is the magnitude of the signed result, saturated to 2^(SIG_BITS-1)-1.
REQ-025 peak_clr without out_valid: peak <= 0 on the next edge.
REQ-026 peak_clr on the same cycle as out_valid: peak <= |r| of that sample (the clear takes priority over the old value; the new sample is not lost).
REQ-027 A gain or mute change during a ramp shall redirect the ramp from the current cur_gain; there is no restart and no jump.

Reset
REQ-028 While reset_n = 0: cur_gain = 0, out_data = 2^(SIG_BITS-1) (0x8000), out_valid = 0, all pipeline valid bits = 0, peak = 0, state derived from cur_gain = 0.
REQ-029 Reset asserted mid-pipeline shall discard in-flight samples; no out_valid shall follow reset release unless a new in_valid arrives.
REQ-030 After reset release, output amplitude shall ramp up from 0 (soft start).

Verification
REQ-031 Ramp: reset, gain = 10, mute = 0, 12 valid samples -> applied gain sequence 0,1,...,10,10; ramping deasserts after the 10th sample.
REQ-032 Arithmetic: after settling at gain = 128, in_data = 0xC000 -> out_data = 0xA000; at gain = 255, in_data = 0x0000 -> out_data = 0x0080, peak = 0x7F80.
REQ-033 Rounding: settled gain = 1, in_data = 0x7FFF (s = -1) -> out_data = 0x7FFF; in_data = 0x8001 -> out_data = 0x8000.
REQ-034 Mute and latency: settled gain = 3, mute = 1, 4 back-to-back samples of 0xFFFF -> out_valid on cycles +2..+5, applied gains 3,2,1,0, final out_data = 0x8000.
REQ-035 Peak clear collision: assert peak_clr on the same cycle as out_valid carrying |r| = 0x0100 with peak = 0x7F80 -> peak = 0x0100; peak_clr alone -> peak = 0.
REQ-036 Reset mid-operation: assert reset_n = 0 with two samples in flight -> no out_valid, out_data = 0x8000, cur_gain = 0 after release.
